// File: rtl/keypad_matrix_driver.sv
// Purpose: simulated 4x4 keypad that closes a queued key against a one-hot column scan.
// Latency: rows follow cols combinationally; an accepted press closes the contact one clock later.
// Backpressure: key_ready is high only in IDLE; a press is taken on key_valid & key_ready.
module keypad_matrix_driver #(
    parameter int HOLD_SCANS    = 4,
    parameter int GAP_SCANS     = 2,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       contact,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_SCANS - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_SCANS - 1);
    localparam logic [7:0] BNC_LAST   = 8'(BOUNCE_CYCLES - 1);
    localparam bit         HAS_BOUNCE = (BOUNCE_CYCLES > 0);

    state_t     state_q, state_d;
    logic [3:0] code_q, code_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [7:0] scnt_q, scnt_d;
    logic       contact_q, contact_d;
    logic       done_q, done_d;
    logic       cols0_q;
    logic       scan_edge;

    // One rising edge of column 0 marks the start of a new full scan.
    assign scan_edge = cols[0] & ~cols0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= 4'd0;
            bcnt_q    <= 8'd0;
            scnt_q    <= 8'd0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            cols0_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            bcnt_q    <= bcnt_d;
            scnt_q    <= scnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            cols0_q   <= cols[0];
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        bcnt_d  = bcnt_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    code_d  = key_code;
                    bcnt_d  = 8'd0;
                    scnt_d  = 8'd0;
                    state_d = HAS_BOUNCE ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN: begin
                if (bcnt_q == BNC_LAST) begin
                    bcnt_d  = 8'd0;
                    state_d = HOLD;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (scan_edge) begin
                    if (scnt_q == HOLD_LAST) begin
                        scnt_d  = 8'd0;
                        bcnt_d  = 8'd0;
                        state_d = HAS_BOUNCE ? BOUNCE_OUT : GAP;
                    end else begin
                        scnt_d = scnt_q + 8'd1;
                    end
                end
            end
            BOUNCE_OUT: begin
                if (bcnt_q == BNC_LAST) begin
                    bcnt_d  = 8'd0;
                    state_d = GAP;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            GAP: begin
                if (scan_edge) begin
                    if (scnt_q == GAP_LAST) begin
                        scnt_d  = 8'd0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        scnt_d = scnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Contact is registered, so it is derived from the state being entered.
        case (state_d)
            BOUNCE_IN:  contact_d = ~bcnt_d[0];
            HOLD:       contact_d = 1'b1;
            BOUNCE_OUT: contact_d = bcnt_d[0];
            default:    contact_d = 1'b0;
        endcase
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = ~key_ready;
    assign contact   = contact_q;
    assign done      = done_q;
    assign rows      = (contact_q && cols[code_q[1:0]]) ? (4'b0001 << code_q[3:2]) : 4'b0000;

endmodule

// File: tb/tb_keypad_matrix_driver.sv
// Bench for keypad_matrix_driver: a no-bounce and a bouncing instance share stimulus
// and are checked every cycle against a remaining-count reference model.
`timescale 1ns/1ps
module tb_keypad_matrix_driver;

    localparam int H0 = 4, G0 = 2, B0 = 0;
    localparam int H1 = 2, G1 = 1, B1 = 3;

    logic            clk;
    logic            rst;
    logic [3:0]      cols;
    logic            key_valid;
    logic [3:0]      key_code;
    logic [1:0][3:0] rows_w;
    logic [1:0]      ready_w, busy_w, contact_w, done_w;

    int n_chk  = 0;
    int n_fail = 0;

    keypad_matrix_driver #(.HOLD_SCANS(H0), .GAP_SCANS(G0), .BOUNCE_CYCLES(B0)) u0 (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows_w[0]),
        .key_valid(key_valid), .key_code(key_code), .key_ready(ready_w[0]),
        .busy(busy_w[0]), .contact(contact_w[0]), .done(done_w[0])
    );

    keypad_matrix_driver #(.HOLD_SCANS(H1), .GAP_SCANS(G1), .BOUNCE_CYCLES(B1)) u1 (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows_w[1]),
        .key_valid(key_valid), .key_code(key_code), .key_ready(ready_w[1]),
        .busy(busy_w[1]), .contact(contact_w[1]), .done(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Reference model: 0 idle, 1 chatter-in, 2 closed, 3 chatter-out, 4 open gap.
    int         mode   [2];
    int         rem    [2];
    int         el     [2];
    logic [3:0] mcode  [2];
    logic       mprev0 [2];
    logic       mdone  [2];

    function automatic int hp(int i); return (i == 0) ? H0 : H1; endfunction
    function automatic int gp(int i); return (i == 0) ? G0 : G1; endfunction
    function automatic int bp(int i); return (i == 0) ? B0 : B1; endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; rem[i] = 0; el[i] = 0;
            mcode[i] = 4'd0; mprev0[i] = 1'b0; mdone[i] = 1'b0;
        end
    endtask

    function automatic logic m_contact(int i);
        case (mode[i])
            1:       return (el[i] % 2) == 0;
            2:       return 1'b1;
            3:       return (el[i] % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_rows(int i, logic [3:0] c);
        logic [3:0] k;
        k = mcode[i];
        if (m_contact(i) && c[k[1:0]]) return 4'(4'b0001 << k[3:2]);
        return 4'b0000;
    endfunction

    task automatic model_step(int i, logic v, logic [3:0] code, logic [3:0] c);
        logic seen;
        seen      = c[0] && !mprev0[i];
        mprev0[i] = c[0];
        mdone[i]  = 1'b0;
        case (mode[i])
            0: if (v) begin
                mcode[i] = code;
                if (bp(i) > 0) begin mode[i] = 1; el[i] = 0; end
                else begin mode[i] = 2; rem[i] = hp(i); end
            end
            1: begin
                el[i]++;
                if (el[i] == bp(i)) begin mode[i] = 2; rem[i] = hp(i); end
            end
            2: if (seen) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    if (bp(i) > 0) begin mode[i] = 3; el[i] = 0; end
                    else begin mode[i] = 4; rem[i] = gp(i); end
                end
            end
            3: begin
                el[i]++;
                if (el[i] == bp(i)) begin mode[i] = 4; rem[i] = gp(i); end
            end
            4: if (seen) begin
                rem[i]--;
                if (rem[i] == 0) begin mode[i] = 0; mdone[i] = 1'b1; end
            end
            default: ;
        endcase
    endtask

    task automatic chk(string nm, int i, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d t=%0t: got %h, expected %h", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_all(int i);
        chk("contact",   i, {3'b0, contact_w[i]}, {3'b0, m_contact(i)});
        chk("key_ready", i, {3'b0, ready_w[i]},   {3'b0, mode[i] == 0});
        chk("busy",      i, {3'b0, busy_w[i]},    {3'b0, mode[i] != 0});
        chk("done",      i, {3'b0, done_w[i]},    {3'b0, mdone[i]});
        chk("rows",      i, rows_w[i],            m_rows(i, cols));
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(logic v, logic [3:0] code, logic [3:0] c);
        key_valid = v;
        key_code  = code;
        cols      = c;
        #1;
        for (int i = 0; i < 2; i++) check_all(i);
        for (int i = 0; i < 2; i++) model_step(i, v, code, c);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] c;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] bounce_exp [4];
    int         acc, n_done, ring, sel;
    logic       take;

    initial begin
        // Key 0110 (row 1, column 2) latched in both instances.
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 4'b0000};
        tbl[2] = '{4'b0010, 4'b0000};
        tbl[3] = '{4'b0100, 4'b0010};
        tbl[4] = '{4'b1000, 4'b0000};
        tbl[5] = '{4'b1111, 4'b0010};
        tbl[6] = '{4'b0110, 4'b0010};
        tbl[7] = '{4'b1011, 4'b0000};
        bounce_exp[0] = 4'd1; bounce_exp[1] = 4'd0;
        bounce_exp[2] = 4'd1; bounce_exp[3] = 4'd1;

        rst = 1'b1; cols = 4'b1111; key_valid = 1'b0; key_code = 4'd0;
        model_reset();
        #5;
        for (int i = 0; i < 2; i++) check_all(i);
        @(negedge clk);
        rst = 1'b0;

        // Accept with the scan stopped: chatter on u1, then a press that never ends.
        cycle(1'b1, 4'b0110, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            chk("bounce_in", 1, {3'b0, contact_w[1]}, bounce_exp[k]);
            chk("hold_contact", 0, {3'b0, contact_w[0]}, 4'd1);
            cycle(1'b0, 4'b0000, 4'b0000);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            chk("stuck_busy", i, {3'b0, busy_w[i]}, 4'd1);
            chk("stuck_done", i, {3'b0, done_w[i]}, 4'd0);
            chk("stuck_rows", i, rows_w[i], 4'b0000);
        end

        foreach (tbl[n]) begin
            cols = tbl[n].c;
            #1;
            for (int i = 0; i < 2; i++) chk("rows_decode", i, rows_w[i], tbl[n].exp);
        end
        cols = 4'b0000;

        // Asynchronous reset in the middle of the hold.
        cols = 4'b0100;
        #1;
        chk("pre_reset_rows", 0, rows_w[0], 4'b0010);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rows",    i, rows_w[i],             4'b0000);
            chk("rst_contact", i, {3'b0, contact_w[i]},  4'd0);
            chk("rst_ready",   i, {3'b0, ready_w[i]},    4'd1);
            chk("rst_done",    i, {3'b0, done_w[i]},     4'd0);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; cols = 4'b0000;

        // Sweep all 16 codes back to back on a running ring counter.
        acc = 0; n_done = 0; ring = 0;
        for (int k = 0; k < 2000; k++) begin
            if (acc == 16 && mode[0] == 0 && mode[1] == 0) break;
            take = (acc < 16) && (mode[0] == 0);
            cycle(acc < 16, 4'(acc), 4'(4'b0001 << ring));
            ring = (ring + 1) % 4;
            if (take) acc++;
            if (done_w[0]) n_done++;
        end
        chk("sweep_done_count", 0, 4'(n_done), 4'(16));
        chk("sweep_accepted",   0, 4'(acc),    4'(16));

        // Multi-hot columns: only the first 0->1 of column 0 counts as a scan.
        cycle(1'b1, 4'b1011, 4'b0000);
        for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) cycle(1'b0, 4'b0000, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            chk("multihot_rows",    i, rows_w[i],            4'b0100);
            chk("multihot_contact", i, {3'b0, contact_w[i]}, 4'd1);
        end

        // Random traffic, mostly a proper scan with occasional glitches.
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       cols = 4'(4'b0001 << ring);
            else if (sel == 7) cols = 4'b0000;
            else if (sel == 8) cols = 4'b1111;
            else               cols = 4'($urandom_range(0, 15));
            ring = (ring + 1) % 4;
            cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), cols);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_driver.md
Name: keypad_matrix_driver

Overview:
Synthesizable model of a 4x4 mechanical keypad, sitting on the far side of the matrix interface. It watches the one-hot column scan produced by fsm_ringcounter4 and drives the row lines as if a commanded key were physically pressed. Key presses are queued through a valid/ready handshake. Each press is held for a programmable number of full column scans, with optional contact bounce at press and at release. It is used to exercise keyboard_read and the calculator front end in self-checking benches and on-board loopback.

Parameters:
HOLD_SCANS, 4, full column scans the key stays closed (1..255)
GAP_SCANS, 2, full column scans the key stays open after release before the next key is accepted (1..255)
BOUNCE_CYCLES, 0, clocks of contact chatter at the start of press and at the start of release (0..255; 0 disables bounce)

Ports:
clk  input  1  system clock, same clock that steps the column ring counter
rst  input  1  asynchronous, active-high reset
cols  input  4  column scan, nominally one-hot; cols[c] high means column c is driven
rows  output  4  row return lines; rows[r] high means row r is connected to the active column
key_valid  input  1  request to press key_code
key_code  input  4  [3:2] = row index r, [1:0] = column index c
key_ready  output  1  high only in IDLE; a press is accepted on key_valid & key_ready
busy  output  1  high in every state except IDLE
contact  output  1  current state of the simulated switch contact (1 = closed)
done  output  1  one-clock pulse on the cycle the FSM returns to IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; contact=0; rows=0; key_ready=1; busy=0; done=0; latched code=0; all counters=0; cols0_q=0.
- Row output is combinational, zero latency from cols:
  - rows = contact & cols[c] ? (4'b0001 << r) : 4'b0000, with r and c taken from the latched code.
  - If cols is multi-hot, rows follows cols[c] only.
  - cols=0 gives rows=0.
- Scan edge:
  - cols0_q <= cols[0] every clock, in every state.
  - scan_edge = cols[0] & ~cols0_q.
  - One scan_edge marks one full scan.
- IDLE: key_ready=1, contact=0.
  - On key_valid, latch key_code, clear counters.
  - Go to BOUNCE_IN if BOUNCE_CYCLES>0, else HOLD.
  - key_code is ignored when key_valid is low.
- BOUNCE_IN: contact = ~bcnt[0], so closed on the first cycle and toggling each clock.
  - Go to HOLD when bcnt reaches BOUNCE_CYCLES-1.
  - scan_edge is not counted here.
- HOLD: contact=1. Increment scnt on each scan_edge.
  - On the clock where scan_edge occurs with scnt==HOLD_SCANS-1: clear counters.
  - Then go to BOUNCE_OUT if BOUNCE_CYCLES>0, else GAP.
- BOUNCE_OUT: contact = bcnt[0], so open on the first cycle and toggling.
  - Go to GAP after BOUNCE_CYCLES clocks.
- GAP: contact=0. Count scan_edge the same way as HOLD.
  - After GAP_SCANS edges go to IDLE and assert done for exactly that transition clock (registered, high in the first IDLE cycle).
- Latency: request accepted at clock edge T gives contact=1 from T+1.
  - A scan_edge in the first HOLD cycle is counted.
- contact is a registered output. bcnt and scnt are 8-bit and saturate-free (parameters are range-limited).
- key_valid held high continuously: a new press is accepted on the first IDLE cycle; done and acceptance coincide in that cycle.
- Reset mid-press: rows and contact drop in the same delta; the pending key is discarded with no done pulse.
- cols stuck (no scan_edge): the block stays in HOLD or GAP indefinitely; there is no timeout.

Test Plan:
- Reset, HOLD_SCANS=4, with fsm_ringcounter4 on cols. Send key_code=4'b0110 -> rows=4'b0010 exactly while cols=4'b0100, rows=0 otherwise. Press lasts 4 full scans (16 clk). done pulses once and keyboard_read reports one press of the row1/col2 key.
- Sweep all 16 key_codes back-to-back with key_valid held high -> each row/col pair is decoded once. key_ready is low between accept and done; 16 done pulses total.
- BOUNCE_CYCLES=3, key_code=4'b0000 -> contact goes 1,0,1 then steady 1. The same chatter inverted appears at release, so keyboard_read's debounce must yield exactly one event.
- Hold cols=4'b0000 after a request is accepted -> rows stays 0 and busy stays 1 with no done. Restarting the ring counter completes the press normally.
- Assert rst in mid-HOLD -> rows=0, contact=0, key_ready=1 immediately and no done. The next request is accepted cleanly.
- Force cols=4'b1111 during HOLD with key_code=4'b1011 -> rows=4'b0100. scan_edge is counted only on a 0->1 transition of cols[0].
